// File: rtl/led_pkg.sv
// Shared types and helpers for the multi-channel LED driver.
package led_pkg;

    typedef enum logic [1:0] {
        LED_OFF   = 2'd0,
        LED_ON    = 2'd1,
        LED_BLINK = 2'd2,
        LED_PWM   = 2'd3
    } led_mode_t;

    function automatic int calc_div(input int clk_hz, input int tick_hz);
        return clk_hz / tick_hz;
    endfunction

    // Counter width able to hold 0..div-1, never narrower than one bit.
    function automatic int cnt_width(input int div);
        return (div <= 2) ? 1 : $clog2(div);
    endfunction

endpackage

// File: rtl/led_tick_gen.sv
// Prescaler producing a one-cycle tick every CLK_FREQ_HZ/TICK_HZ clocks; clr restarts the count.
module led_tick_gen
    import led_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 27_000_000,
    parameter int TICK_HZ     = 1000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic tick
);

    localparam int DIV = calc_div(CLK_FREQ_HZ, TICK_HZ);
    localparam int CW  = cnt_width(DIV);

    logic [CW-1:0] cnt_q, cnt_d;

    assign tick = (cnt_q == CW'(DIV - 1));

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (clr || tick) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/led_multi_blink.sv
// Multi-channel LED driver: per-channel OFF/ON/BLINK/PWM with a shared prescaler tick.
// Define LED_ACTIVE_LOW_EN to invert led_out at the output register.
module led_multi_blink
    import led_pkg::*;
#(
    parameter int CLK_FREQ_HZ       = 27_000_000,
    parameter int TICK_HZ           = 1000,
    parameter int NUM_CH            = 4,
    parameter int PERIOD_W          = 16,
    parameter int DUTY_W            = 8,
    parameter int RESET_HALF_PERIOD = 500
) (
    input  logic                                        clk,
    input  logic                                        rst_n,
    input  logic                                        cfg_valid,
    output logic                                        cfg_ready,
    input  logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] cfg_ch,
    input  logic [1:0]                                  cfg_mode,
    input  logic [PERIOD_W-1:0]                         cfg_half_period,
    input  logic [DUTY_W-1:0]                           cfg_duty,
    output logic                                        cfg_err,
    input  logic                                        sync_i,
    output logic [NUM_CH-1:0]                           led_out
);

    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic              tick;
    logic              ready_q, err_q, err_d;
    logic              ch_bad, wr_ok;
    logic [DUTY_W-1:0] pwm_q, pwm_d;
    logic [NUM_CH-1:0] led_q, led_d;

    led_tick_gen #(
        .CLK_FREQ_HZ (CLK_FREQ_HZ),
        .TICK_HZ     (TICK_HZ)
    ) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (sync_i),
        .tick  (tick)
    );

    // Widen by one bit so the range check stays meaningful when NUM_CH is a power of two.
    assign ch_bad = ({1'b0, cfg_ch} >= (CH_W + 1)'(NUM_CH));
    assign wr_ok  = cfg_valid && ready_q && !ch_bad;
    assign err_d  = cfg_valid && ready_q && ch_bad;
    assign pwm_d  = pwm_q + 1'b1;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        led_mode_t           mode_q, mode_d;
        logic [PERIOD_W-1:0] hp_q, hp_d, bcnt_q, bcnt_d, hp_last;
        logic [DUTY_W-1:0]   duty_q, duty_d;
        logic                st_q, st_d, hit;

        assign hit     = wr_ok && (cfg_ch == CH_W'(i));
        assign hp_last = (hp_q == '0) ? '0 : hp_q - 1'b1;

        // Config and sync take priority over a coincident tick.
        always_comb begin
            mode_d = mode_q;
            hp_d   = hp_q;
            duty_d = duty_q;
            bcnt_d = bcnt_q;
            st_d   = st_q;
            if (hit) begin
                mode_d = led_mode_t'(cfg_mode);
                hp_d   = cfg_half_period;
                duty_d = cfg_duty;
            end
            if (hit || sync_i) begin
                bcnt_d = '0;
                st_d   = 1'b1;
            end else if (tick) begin
                if (bcnt_q >= hp_last) begin
                    bcnt_d = '0;
                    st_d   = ~st_q;
                end else begin
                    bcnt_d = bcnt_q + 1'b1;
                end
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                mode_q <= LED_BLINK;
                hp_q   <= PERIOD_W'(RESET_HALF_PERIOD);
                duty_q <= '0;
                bcnt_q <= '0;
                st_q   <= 1'b0;
            end else begin
                mode_q <= mode_d;
                hp_q   <= hp_d;
                duty_q <= duty_d;
                bcnt_q <= bcnt_d;
                st_q   <= st_d;
            end
        end

        assign led_d[i] = (mode_q == LED_ON)    ? 1'b1 :
                          (mode_q == LED_BLINK) ? st_q :
                          (mode_q == LED_PWM)   ? (pwm_q < duty_q) : 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_q <= 1'b0;
            err_q   <= 1'b0;
            pwm_q   <= '0;
`ifdef LED_ACTIVE_LOW_EN
            led_q   <= '1;
`else
            led_q   <= '0;
`endif
        end else begin
            ready_q <= 1'b1;
            err_q   <= err_d;
            pwm_q   <= pwm_d;
`ifdef LED_ACTIVE_LOW_EN
            led_q   <= ~led_d;
`else
            led_q   <= led_d;
`endif
        end
    end

    assign cfg_ready = ready_q;
    assign cfg_err   = err_q;
    assign led_out   = led_q;

endmodule

// File: tb/tb_led_multi_blink.sv
// Scoreboard bench for led_multi_blink (DIV=10, 4 channels, 4-bit PWM, reset half-period 3).
module tb_led_multi_blink;

    localparam int DIV = 10;
    localparam int NCH = 4;
`ifdef LED_ACTIVE_LOW_EN
    localparam logic [3:0] POL  = 4'b1111;
    localparam logic [4:0] POL5 = 5'b11111;
`else
    localparam logic [3:0] POL  = 4'b0000;
    localparam logic [4:0] POL5 = 5'b00000;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cfg_valid = 1'b0;
    logic        cfg_ready;
    logic [1:0]  cfg_ch = '0;
    logic [1:0]  cfg_mode = '0;
    logic [15:0] cfg_half_period = '0;
    logic [3:0]  cfg_duty = '0;
    logic        cfg_err;
    logic        sync_i = 1'b0;
    logic [3:0]  led_out;

    logic        cfg_valid5 = 1'b0;
    logic [2:0]  cfg_ch5 = '0;
    logic        cfg_ready5, cfg_err5;
    logic [4:0]  led_out5;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    led_multi_blink #(
        .CLK_FREQ_HZ(1000), .TICK_HZ(100), .NUM_CH(4), .PERIOD_W(16),
        .DUTY_W(4), .RESET_HALF_PERIOD(3)
    ) u_dut (
        .clk(clk), .rst_n(rst_n), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_ch(cfg_ch), .cfg_mode(cfg_mode), .cfg_half_period(cfg_half_period),
        .cfg_duty(cfg_duty), .cfg_err(cfg_err), .sync_i(sync_i), .led_out(led_out)
    );

    // Five channels give a 3-bit channel select, so an out-of-range index is expressible.
    led_multi_blink #(
        .CLK_FREQ_HZ(1000), .TICK_HZ(100), .NUM_CH(5), .PERIOD_W(16),
        .DUTY_W(4), .RESET_HALF_PERIOD(3)
    ) u_dut5 (
        .clk(clk), .rst_n(rst_n), .cfg_valid(cfg_valid5), .cfg_ready(cfg_ready5),
        .cfg_ch(cfg_ch5), .cfg_mode(cfg_mode), .cfg_half_period(cfg_half_period),
        .cfg_duty(cfg_duty), .cfg_err(cfg_err5), .sync_i(1'b0), .led_out(led_out5)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: behavioural view of the main instance, stepped on each rising edge.
    int         m_pre, m_pwm;
    int         m_mode[NCH], m_hp[NCH], m_duty[NCH], m_bcnt[NCH];
    bit         m_st[NCH];
    bit         m_ready;
    logic [5:0] exp_q[$];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pre = 0; m_pwm = 0; m_ready = 0;
            for (int i = 0; i < NCH; i++) begin
                m_mode[i] = 2; m_hp[i] = 3; m_duty[i] = 0; m_bcnt[i] = 0; m_st[i] = 0;
            end
            exp_q.delete();
        end else begin
            logic [3:0] e_led;
            bit tk, wr;
            tk = (m_pre == DIV - 1);
            wr = cfg_valid && m_ready;
            for (int i = 0; i < NCH; i++) begin
                case (m_mode[i])
                    0: e_led[i] = 1'b0;
                    1: e_led[i] = 1'b1;
                    2: e_led[i] = m_st[i];
                    default: e_led[i] = (m_pwm < m_duty[i]);
                endcase
            end
            for (int i = 0; i < NCH; i++) begin
                bit hit;
                int hpe;
                hit = wr && (int'(cfg_ch) == i);
                if (hit) begin
                    m_mode[i] = int'(cfg_mode);
                    m_hp[i]   = int'(cfg_half_period);
                    m_duty[i] = int'(cfg_duty);
                end
                hpe = (m_hp[i] == 0) ? 1 : m_hp[i];
                if (hit || sync_i) begin
                    m_bcnt[i] = 0; m_st[i] = 1;
                end else if (tk) begin
                    if (m_bcnt[i] + 1 >= hpe) begin
                        m_bcnt[i] = 0; m_st[i] = !m_st[i];
                    end else begin
                        m_bcnt[i]++;
                    end
                end
            end
            m_pre   = (sync_i || tk) ? 0 : m_pre + 1;
            m_pwm   = (m_pwm + 1) % 16;
            m_ready = 1;
            exp_q.push_back({e_led ^ POL, 1'b1, 1'b0});
        end
    end

    always @(negedge clk) begin
        if (rst_n === 1'b1 && exp_q.size() > 0) begin
            logic [5:0] e;
            e = exp_q.pop_front();
            check_val("led", 32'(led_out), 32'(e[5:2]));
            check_val("rdy", 32'(cfg_ready), 32'(e[1]));
            check_val("err", 32'(cfg_err), 32'(e[0]));
        end
    end

    function automatic logic act(input int ch);
        return led_out[ch] ^ POL[ch];
    endfunction

    task automatic wr_cfg(input int ch, input int mode, input int hp, input int duty);
        cfg_valid = 1'b1; cfg_ch = 2'(ch); cfg_mode = 2'(mode);
        cfg_half_period = 16'(hp); cfg_duty = 4'(duty);
        @(negedge clk);
        cfg_valid = 1'b0;
    endtask

    // Measures a complete run of level lvl on channel ch (skips any partial run in progress).
    task automatic meas_run(input int ch, input logic lvl, input string tag, input int exp_len);
        bit ok;
        int n;
        ok = 0;
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            if (act(ch) != lvl) begin ok = 1; break; end
        end
        if (ok) begin
            ok = 0;
            for (int k = 0; k < 400; k++) begin
                @(negedge clk);
                if (act(ch) == lvl) begin ok = 1; break; end
            end
        end
        if (!ok) begin
            check_val({tag, "_timeout"}, 32'd0, 32'd1);
            return;
        end
        n = 0;
        while (act(ch) == lvl && n < 400) begin
            n++;
            @(negedge clk);
        end
        check_val(tag, 32'(n), 32'(exp_len));
    endtask

    task automatic wait_cyc(input int n);
        for (int k = 0; k < n; k++) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        #1 rst_n = 1'b0;
        #2;
        check_val("rst_led", 32'(led_out), 32'(POL));
        check_val("rst_rdy", 32'(cfg_ready), 32'd0);
        wait_cyc(3);
        rst_n = 1'b1;
        check_val("rel_rdy0", 32'(cfg_ready), 32'd0);
        check_val("rel_led", 32'(led_out), 32'(POL));

        // Default blink: all channels toggle together, 30 clocks per level.
        meas_run(0, 1'b1, "dflt_hi", 30);
        meas_run(0, 1'b0, "dflt_lo", 30);
        check_val("dflt_same", 32'(led_out ^ POL), {32{act(0)}} & 32'hF);

        wr_cfg(1, 1, 0, 0);
        wr_cfg(2, 0, 0, 0);
        wr_cfg(3, 3, 0, 4);
        wait_cyc(3);
        cnt = 0;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            cnt += int'(act(3));
        end
        check_val("pwm4_cnt", 32'(cnt), 32'd4);
        check_val("ch1_on", 32'(act(1)), 32'd1);
        check_val("ch2_off", 32'(act(2)), 32'd0);
        wr_cfg(3, 3, 0, 15);
        wait_cyc(3);
        cnt = 0;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            cnt += int'(act(3));
        end
        check_val("pwm15_cnt", 32'(cnt), 32'd15);

        wr_cfg(0, 2, 0, 0);
        meas_run(0, 1'b1, "hp0_hi", 10);
        meas_run(0, 1'b0, "hp0_lo", 10);
        wr_cfg(0, 2, 5, 0);
        @(negedge clk);
        check_val("hp5_start", 32'(act(0)), 32'd1);
        meas_run(0, 1'b1, "hp5_hi", 50);
        meas_run(0, 1'b0, "hp5_lo", 50);

        // Out-of-range channel on the five-channel instance.
        cfg_valid5 = 1'b1; cfg_ch5 = 3'd4; cfg_mode = 2'd1;
        @(negedge clk);
        cfg_valid5 = 1'b0;
        check_val("ch4_noerr", 32'(cfg_err5), 32'd0);
        @(negedge clk);
        check_val("ch4_on", 32'(led_out5[4] ^ POL5[4]), 32'd1);
        cfg_valid5 = 1'b1; cfg_ch5 = 3'd5; cfg_mode = 2'd0;
        @(negedge clk);
        cfg_valid5 = 1'b0;
        check_val("err_pulse", 32'(cfg_err5), 32'd1);
        @(negedge clk);
        check_val("err_clear", 32'(cfg_err5), 32'd0);
        check_val("err_nochg", 32'(led_out5[4] ^ POL5[4]), 32'd1);

        // Mixed phases, then sync; then sync together with a write.
        wr_cfg(1, 2, 2, 0);
        wait_cyc(7);
        wr_cfg(3, 2, 3, 0);
        wait_cyc(13);
        sync_i = 1'b1;
        @(negedge clk);
        sync_i = 1'b0;
        @(negedge clk);
        check_val("sync_hi0", 32'(act(0)), 32'd1);
        check_val("sync_hi1", 32'(act(1)), 32'd1);
        check_val("sync_hi3", 32'(act(3)), 32'd1);
        wait_cyc(27);
        sync_i = 1'b1;
        wr_cfg(2, 2, 4, 0);
        sync_i = 1'b0;
        @(negedge clk);
        check_val("sync_wr_all", 32'(led_out ^ POL), 32'hF);
        wait_cyc(120);

        // Asynchronous reset mid-blink.
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check_val("async_led", 32'(led_out), 32'(POL));
        check_val("async_rdy", 32'(cfg_ready), 32'd0);
        wait_cyc(2);
        rst_n = 1'b1;
        meas_run(2, 1'b1, "post_rst_hi", 30);
        wait_cyc(20);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
